// File: rtl/bcd_converter.sv
// ============================================================================
// bcd_converter
// ----------------------------------------------------------------------------
// Sequential binary-to-BCD converter. It uses shift-and-add-3 (double dabble)
// and handles one input bit per clock. A start/done handshake controls it.
// The last result stays on bcd_out/overflow until the next LATCH edge.
//
// Parameters:
//   WIDTH   - binary input width in bits (>= 1)
//   DIGITS  - number of BCD output digits (>= 1)
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   start    in   conversion request, sampled only while idle
//   bin_in   in   unsigned binary value, captured on the accepting edge
//   busy     out  high while a conversion is in progress
//   done     out  one-cycle pulse when bcd_out/overflow update
//   bcd_out  out  packed BCD, digit 0 (ones) in [3:0]
//   overflow out  last captured value exceeded 10^DIGITS - 1
//
// Optional feature macro: BCD_CONVERTER_AUTO_START_EN
//   When it is defined, an idle converter also starts a conversion when
//   bin_in differs from the value captured by the last conversion. Reset
//   counts as having captured 0.
// ============================================================================
module bcd_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   // The counter only needs to reach WIDTH-1. The last iteration is detected
   // by value, so the wrap after it does not matter.
   localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

   // This is the largest value that DIGITS decimal digits can show.
   // It saturates so that very large DIGITS cannot wrap the 64-bit product.
   function automatic logic [63:0] max_value();
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (p > 64'd1844674407370955160) begin
            return '1;
         end
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_value();

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

   state_t              state_q,    state_d;
   logic [WIDTH-1:0]    bin_q,      bin_d;
   logic [BCD_W-1:0]    scratch_q,  scratch_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic                ovf_pend_q, ovf_pend_d;
   logic [BCD_W-1:0]    bcd_q,      bcd_d;
   logic                overflow_q, overflow_d;
   logic                done_q,     done_d;
`ifdef BCD_CONVERTER_AUTO_START_EN
   logic [WIDTH-1:0]    last_q,     last_d;
`endif

   logic [BCD_W-1:0]    adjusted;
   logic [63:0]         bin_ext;
   logic                launch;

   assign bin_ext = 64'(bin_in);

   // Add 3 to every scratch digit that is 5 or more. After the shift, such a
   // digit carries into the next digit, so no digit ever exceeds 9.
   always_comb begin
      adjusted = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

`ifdef BCD_CONVERTER_AUTO_START_EN
   assign launch = start || (bin_in != last_q);
`else
   assign launch = start;
`endif

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
`ifdef BCD_CONVERTER_AUTO_START_EN
      last_d     = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (launch) begin
               bin_d      = bin_in;
               scratch_d  = '0;
               cnt_d      = '0;
               ovf_pend_d = (bin_ext > MAX_VAL);
               state_d    = SHIFT;
`ifdef BCD_CONVERTER_AUTO_START_EN
               last_d     = bin_in;
`endif
            end
         end
         SHIFT: begin
            // Shift {scratch, binary} left as one long register.
            scratch_d = {adjusted[BCD_W-2:0], bin_q[WIDTH-1]};
            bin_d     = bin_q << 1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            bcd_d      = ovf_pend_q ? ALL_NINES : scratch_q;
            overflow_d = ovf_pend_q;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef BCD_CONVERTER_AUTO_START_EN
         last_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
`ifdef BCD_CONVERTER_AUTO_START_EN
         last_q     <= last_d;
`endif
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_converter.sv
// ============================================================================
// tb_bcd_converter
// ----------------------------------------------------------------------------
// Self-checking bench for bcd_converter. It drives a 3-digit instance and a
// 2-digit instance. Expected BCD words come from a decimal reference model
// built from plain division and modulo.
// ============================================================================
module tb_bcd_converter;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  bin_in;
   logic        busy;
   logic        done;
   logic [11:0] bcd_out;
   logic        overflow;

   logic        start2;
   logic [7:0]  bin2;
   logic        busy2;
   logic        done2;
   logic [7:0]  bcd2;
   logic        ovf2;

   int n_checks;
   int n_pass;

   // Expected value of the 3-digit result currently held by the DUT.
   logic [11:0] exp_held;

   bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .overflow (overflow)
   );

   bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clock    (clock),
      .reset    (reset),
      .start    (start2),
      .bin_in   (bin2),
      .busy     (busy2),
      .done     (done2),
      .bcd_out  (bcd2),
      .overflow (ovf2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: decimal digits by division, or all nines when the
   // value cannot be shown in the given number of digits.
   function automatic logic [31:0] model_bcd(input int value, input int digits);
      int limit;
      int v;
      logic [31:0] r;
      limit = 1;
      for (int i = 0; i < digits; i++) limit = limit * 10;
      r = '0;
      v = value;
      for (int i = 0; i < digits; i++) begin
         if (value >= limit) r[4*i +: 4] = 4'd9;
         else r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic bit model_ovf(input int value, input int digits);
      int limit;
      limit = 1;
      for (int i = 0; i < digits; i++) limit = limit * 10;
      return value >= limit;
   endfunction

   // Runs one conversion on the 3-digit DUT and watches it for 20 cycles.
   // It reports the latency, the done pulse count, and whether busy and done
   // overlapped. It also reports whether bcd_out kept its old value until done.
   task automatic run_conv(input logic [7:0] value, output int lat, output int pulses,
                           output bit clash, output bit held_ok);
      @(negedge clock);
      bin_in = value;
      start  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
`ifndef BCD_CONVERTER_AUTO_START_EN
      bin_in = 8'($urandom);
`endif
      lat = 0; pulses = 0; clash = 1'b0; held_ok = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock);
         #1;
         if (done) begin
            pulses++;
            if (lat == 0) lat = c;
            if (busy) clash = 1'b1;
         end else if (pulses == 0 && bcd_out !== exp_held) begin
            held_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; bin_in = 8'd0; start2 = 1'b0; bin2 = 8'd0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %0b want 0", done); else n_pass++;
      n_checks++; if (bcd_out !== 12'h000) $display("[TB] FAIL reset_bcd got %h want 000", bcd_out); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf got %0b want 0", overflow); else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      exp_held = 12'h000;
   endtask

   task automatic test_first_zero();
      int lat, pulses; bit clash, held;
      run_conv(8'd0, lat, pulses, clash, held);
      n_checks++; if (lat !== 9) $display("[TB] FAIL zero_latency got %0d want 9", lat); else n_pass++;
      n_checks++; if (pulses !== 1) $display("[TB] FAIL zero_pulses got %0d want 1", pulses); else n_pass++;
      n_checks++; if (bcd_out !== 12'h000) $display("[TB] FAIL zero_bcd got %h want 000", bcd_out); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL zero_ovf got %0b want 0", overflow); else n_pass++;
   endtask

   task automatic test_sweep();
      int vals[9];
      int lat, pulses; bit clash, held;
      logic [11:0] exp;
      vals[0] = 9; vals[1] = 10; vals[2] = 99; vals[3] = 100; vals[4] = 255;
      for (int i = 5; i < 9; i++) vals[i] = $urandom_range(0, 255);
      for (int i = 0; i < 9; i++) begin
         exp = 12'(model_bcd(vals[i], 3));
         run_conv(8'(vals[i]), lat, pulses, clash, held);
         n_checks++; if (lat !== 9) $display("[TB] FAIL sweep_latency v=%0d got %0d want 9", vals[i], lat); else n_pass++;
         n_checks++; if (pulses !== 1) $display("[TB] FAIL sweep_pulses v=%0d got %0d want 1", vals[i], pulses); else n_pass++;
         n_checks++; if (clash !== 1'b0) $display("[TB] FAIL sweep_busy_done v=%0d got overlap want none", vals[i]); else n_pass++;
         n_checks++; if (held !== 1'b1) $display("[TB] FAIL sweep_hold v=%0d got changed want held %h", vals[i], exp_held); else n_pass++;
         n_checks++; if (bcd_out !== exp) $display("[TB] FAIL sweep_bcd v=%0d got %h want %h", vals[i], bcd_out, exp); else n_pass++;
         n_checks++; if (overflow !== model_ovf(vals[i], 3)) $display("[TB] FAIL sweep_ovf v=%0d got %0b want 0", vals[i], overflow); else n_pass++;
         exp_held = exp;
      end
   endtask

   task automatic test_ignore_start();
      int pulses;
      @(negedge clock);
      bin_in = 8'd200; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 3) begin start = 1'b1; bin_in = 8'd7; end
         if (c == 5) start = 1'b0;
         @(posedge clock);
         #1;
         if (done) pulses++;
      end
      n_checks++; if (pulses !== 1) $display("[TB] FAIL ignore_pulses got %0d want 1", pulses); else n_pass++;
      n_checks++; if (bcd_out !== 12'h200) $display("[TB] FAIL ignore_bcd got %h want 200", bcd_out); else n_pass++;
      exp_held = 12'h200;
   endtask

   task automatic test_reset_mid();
      int pulses;
      int lat, p2; bit clash, held;
      @(negedge clock);
      bin_in = 8'd123; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      n_checks++; if (bcd_out !== 12'h000) $display("[TB] FAIL midreset_bcd got %h want 000", bcd_out); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy got %0b want 0", busy); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL midreset_ovf got %0b want 0", overflow); else n_pass++;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      exp_held = 12'h000;
      pulses = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clock);
         #1;
         if (done) pulses++;
      end
      n_checks++; if (pulses !== 0) $display("[TB] FAIL midreset_nodone got %0d want 0", pulses); else n_pass++;
      run_conv(8'd45, lat, p2, clash, held);
      n_checks++; if (bcd_out !== 12'h045) $display("[TB] FAIL midreset_after got %h want 045", bcd_out); else n_pass++;
      n_checks++; if (p2 !== 1) $display("[TB] FAIL midreset_after_pulses got %0d want 1", p2); else n_pass++;
      exp_held = 12'h045;
   endtask

   task automatic test_two_digits();
      int vals[2];
      int seen;
      vals[0] = 100; vals[1] = 42;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         bin2 = 8'(vals[i]); start2 = 1'b1;
         @(posedge clock);
         #1;
         start2 = 1'b0;
         seen = 0;
         for (int c = 1; c <= 20 && seen == 0; c++) begin
            @(posedge clock);
            #1;
            if (done2) seen = c;
         end
         n_checks++; if (seen !== 9) $display("[TB] FAIL two_latency v=%0d got %0d want 9", vals[i], seen); else n_pass++;
         n_checks++; if (bcd2 !== 8'(model_bcd(vals[i], 2))) $display("[TB] FAIL two_bcd v=%0d got %h want %h", vals[i], bcd2, 8'(model_bcd(vals[i], 2))); else n_pass++;
         n_checks++; if (ovf2 !== model_ovf(vals[i], 2)) $display("[TB] FAIL two_ovf v=%0d got %0b want %0b", vals[i], ovf2, model_ovf(vals[i], 2)); else n_pass++;
      end
   endtask

   task automatic test_auto_start();
      int steps[3];
      int pulses;
      logic [11:0] exp_final;
      int exp_pulses;
      steps[0] = 37; steps[1] = 37; steps[2] = 250;
      @(negedge clock);
      start = 1'b0; bin_in = 8'd0; reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         bin_in = 8'(steps[i]);
         for (int c = 0; c < 25; c++) begin
            @(posedge clock);
            #1;
            if (done) pulses++;
         end
      end
`ifdef BCD_CONVERTER_AUTO_START_EN
      exp_pulses = 2;
      exp_final  = 12'(model_bcd(250, 3));
`else
      exp_pulses = 0;
      exp_final  = 12'h000;
`endif
      n_checks++; if (pulses !== exp_pulses) $display("[TB] FAIL auto_pulses got %0d want %0d", pulses, exp_pulses); else n_pass++;
      n_checks++; if (bcd_out !== exp_final) $display("[TB] FAIL auto_bcd got %h want %h", bcd_out, exp_final); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      exp_held = 12'h000;
      test_reset();
      test_first_zero();
      test_sweep();
      test_ignore_start();
      test_reset_mid();
      test_two_digits();
      test_auto_start();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
